// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline's memory stage:
// FSM state encoding, datapath width constants and the fault data pattern.
package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_REG_W  = 4;

   // Returned as load data when an access is abandoned on timeout
   localparam logic [CPU_DATA_W-1:0] FAULT_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: IDLE/WAIT/DONE FSM plus the registered
// req/we/addr/wdata interface toward the data memory.
// Optional macro MEM_TIMEOUT_EN adds an 8-bit WAIT counter that abandons an
// unacknowledged access after TIMEOUT_CYCLES WAIT cycles and flags a fault.
module dmem_req_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W         = CPU_DATA_W,
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_op,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_ack,
   output mem_state_t        o_state,
   output logic              o_req,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_fault
);

   mem_state_t        r_state;
   mem_state_t        w_next;
   logic              w_expire;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   // The wait counter is 8 bits wide, so the limit must fit in it
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("dmem_req_ctrl: TIMEOUT_CYCLES must be in 2..256");
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       r_fault;

   // An ack on the expiry cycle wins, so expiry requires no ack
   assign w_expire = (r_state == S_WAIT) && !i_ack &&
                     (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   // Count WAIT cycles without ack; cleared on entry to WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_IDLE && i_mem_op) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT && !i_ack) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Fault flag is high only during the DONE cycle that follows expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_expire;
      end
   end

   assign o_fault = r_fault;
`else
   assign w_expire = 1'b0;
   assign o_fault  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_mem_op) w_next = S_WAIT;
         S_WAIT:  if (i_ack || w_expire) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request registers: loaded on accept, held through WAIT, req dropped on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (r_state == S_IDLE && i_mem_op) begin
         r_req   <= 1'b1;
         r_we    <= i_we;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
      end else if (r_state == S_WAIT && (i_ack || w_expire)) begin
         r_req   <= 1'b0;
      end
   end

   assign o_state = r_state;
   assign o_req   = r_req;
   assign o_we    = r_we;
   assign o_addr  = r_addr;
   assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit 5-stage pipeline. Runs loads/stores through a
// variable-latency req/ack data-memory interface, stalls upstream while an
// access is outstanding, and presents the write-back fields to pipe_mem_wb.
// Optional macro MEM_TIMEOUT_EN enables the access timeout / mem_fault path.
module mem_access_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W         = CPU_DATA_W,
   parameter int ADDR_W         = 16,
   parameter int REG_W          = CPU_REG_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic              reg_write_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [REG_W-1:0]  rd_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_stall,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] mem_data,
   output logic [REG_W-1:0]  rd,
   output logic              mem_fault
);

   mem_state_t        w_state;
   logic              w_mem_op;
   logic              w_accept;
   logic              w_fault;

   logic              r_mem_to_reg;
   logic              r_reg_write;
   logic [DATA_W-1:0] r_alu_result;
   logic [REG_W-1:0]  r_rd;
   logic              r_is_load;
   logic [DATA_W-1:0] r_mem_data;

   // Both read and write set is treated as a store
   assign w_mem_op = valid_in & (mem_read_in | mem_write_in);
   assign w_accept = (w_state == S_IDLE) & w_mem_op;

   dmem_req_ctrl #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_req_ctrl (
      .clk     (clk),
      .rst     (rst),
      .i_mem_op(w_mem_op),
      .i_we    (mem_write_in),
      .i_addr  (alu_result_in[ADDR_W-1:0]),
      .i_wdata (store_data_in),
      .i_ack   (dmem_ack),
      .o_state (w_state),
      .o_req   (dmem_req),
      .o_we    (dmem_we),
      .o_addr  (dmem_addr),
      .o_wdata (dmem_wdata),
      .o_fault (w_fault)
   );

   // Capture write-back fields on accept; capture load data on ack in WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_alu_result <= '0;
         r_rd         <= '0;
         r_is_load    <= 1'b0;
         r_mem_data   <= '0;
      end else if (w_accept) begin
         r_mem_to_reg <= mem_to_reg_in;
         r_reg_write  <= reg_write_in;
         r_alu_result <= alu_result_in;
         r_rd         <= rd_in;
         r_is_load    <= ~mem_write_in;
         r_mem_data   <= '0;
      end else if (w_state == S_WAIT && dmem_ack && r_is_load) begin
         r_mem_data   <= dmem_rdata;
      end
   end

   // Output muxing: pass-through in IDLE, bubble while busy, captured fields in DONE
   always_comb begin
      mem_stall  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_result = '0;
      mem_data   = '0;
      rd         = '0;
      case (w_state)
         S_IDLE: begin
            if (w_mem_op) begin
               mem_stall = 1'b1;
            end else begin
               reg_write  = valid_in & reg_write_in;
               mem_to_reg = mem_to_reg_in;
               alu_result = alu_result_in;
               rd         = rd_in;
            end
         end
         S_WAIT: begin
            mem_stall = 1'b1;
         end
         S_DONE: begin
            mem_to_reg = r_mem_to_reg;
            reg_write  = r_reg_write & ~w_fault;
            alu_result = r_alu_result;
            rd         = r_rd;
            mem_data   = w_fault ? DATA_W'(FAULT_DATA) : r_mem_data;
         end
         default: begin
            mem_stall = 1'b0;
         end
      endcase
   end

   assign mem_fault = w_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases followed by
// randomized ALU/load/store transactions checked against a transaction-level
// model of expected stall length, memory request contents and write-back fields.
`timescale 1ns/1ps
module tb_mem_access_stage;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int REG_W  = 4;
   localparam int TMO    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              mem_to_reg_in;
   logic              reg_write_in;
   logic [DATA_W-1:0] alu_result_in;
   logic [DATA_W-1:0] store_data_in;
   logic [REG_W-1:0]  rd_in;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;
   logic              dmem_ack;
   logic              mem_stall;
   logic              mem_to_reg;
   logic              reg_write;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] mem_data;
   logic [REG_W-1:0]  rd;
   logic              mem_fault;

   int n_vec = 0;
   int n_err = 0;

   mem_access_stage #(
      .DATA_W        (DATA_W),
      .ADDR_W        (ADDR_W),
      .REG_W         (REG_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .mem_to_reg_in(mem_to_reg_in),
      .reg_write_in (reg_write_in),
      .alu_result_in(alu_result_in),
      .store_data_in(store_data_in),
      .rd_in        (rd_in),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .mem_stall    (mem_stall),
      .mem_to_reg   (mem_to_reg),
      .reg_write    (reg_write),
      .alu_result   (alu_result),
      .mem_data     (mem_data),
      .rd           (rd),
      .mem_fault    (mem_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      valid_in      = 1'b0;
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      mem_to_reg_in = 1'b0;
      reg_write_in  = 1'b0;
      alu_result_in = '0;
      store_data_in = '0;
      rd_in         = '0;
      dmem_ack      = 1'b0;
      dmem_rdata    = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Non-memory slot: outputs must follow inputs in the same cycle
   task automatic alu_op(input logic v, input logic rdin, input logic wrin,
                         input logic rw, input logic m2r, input logic [15:0] res,
                         input logic [3:0] rdx, input logic ack);
      valid_in      = v;
      mem_read_in   = rdin;
      mem_write_in  = wrin;
      mem_to_reg_in = m2r;
      reg_write_in  = rw;
      alu_result_in = res;
      store_data_in = 16'($urandom);
      rd_in         = rdx;
      dmem_ack      = ack;
      dmem_rdata    = 16'($urandom);
      @(negedge clk);
      check("alu_stall", mem_stall, 1'b0);
      check("alu_regwr", reg_write, v & rw);
      check("alu_m2r",   mem_to_reg, m2r);
      check("alu_res",   alu_result, res);
      check("alu_rd",    rd, rdx);
      check("alu_mdata", mem_data, 16'h0);
      check("alu_req",   dmem_req, 1'b0);
      next_cycle();
   endtask

   // Load or store that completes with ack in WAIT cycle number lat
   task automatic mem_txn(input logic we, input logic both, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata,
                          input int lat, input logic rw, input logic m2r,
                          input logic [3:0] rdx);
      valid_in      = 1'b1;
      mem_read_in   = ~we | both;
      mem_write_in  = we;
      mem_to_reg_in = m2r;
      reg_write_in  = rw;
      alu_result_in = addr;
      store_data_in = wdata;
      rd_in         = rdx;
      dmem_ack      = 1'($urandom);
      dmem_rdata    = 16'($urandom);
      @(negedge clk);
      check("acc_stall", mem_stall, 1'b1);
      check("acc_regwr", reg_write, 1'b0);
      check("acc_m2r",   mem_to_reg, 1'b0);
      check("acc_req",   dmem_req, 1'b0);
      next_cycle();
      for (int j = 1; j <= lat; j++) begin
         dmem_ack   = (j == lat);
         dmem_rdata = (j == lat) ? rdata : 16'($urandom);
         @(negedge clk);
         check("wait_stall", mem_stall, 1'b1);
         check("wait_req",   dmem_req, 1'b1);
         check("wait_we",    dmem_we, we);
         check("wait_addr",  dmem_addr, addr);
         check("wait_wdata", dmem_wdata, wdata);
         check("wait_regwr", reg_write, 1'b0);
         check("wait_fault", mem_fault, 1'b0);
         next_cycle();
      end
      dmem_ack   = 1'($urandom);
      dmem_rdata = 16'($urandom);
      @(negedge clk);
      check("done_stall", mem_stall, 1'b0);
      check("done_req",   dmem_req, 1'b0);
      check("done_regwr", reg_write, rw);
      check("done_m2r",   mem_to_reg, m2r);
      check("done_res",   alu_result, addr);
      check("done_rd",    rd, rdx);
      check("done_mdata", mem_data, we ? 16'h0 : rdata);
      check("done_fault", mem_fault, 1'b0);
      next_cycle();
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      #12;
      check("rst_req",   dmem_req, 1'b0);
      check("rst_we",    dmem_we, 1'b0);
      check("rst_addr",  dmem_addr, 16'h0);
      check("rst_wdata", dmem_wdata, 16'h0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_fault", mem_fault, 1'b0);
      check("rst_regwr", reg_write, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      next_cycle();

      // Directed cases
      alu_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 4'd3, 1'b0);
      mem_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1, 1'b1, 1'b1, 4'd5);
      mem_txn(1'b1, 1'b0, 16'h0010, 16'hA5A5, 16'h0000, 4, 1'b0, 1'b0, 4'd0);
      mem_txn(1'b1, 1'b1, 16'h0022, 16'h5A5A, 16'h7777, 2, 1'b0, 1'b0, 4'd1);
      alu_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F, 4'd9, 1'b1);
      alu_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4321, 4'd7, 1'b1);

      // Reset in the middle of WAIT abandons the access immediately
      valid_in      = 1'b1;
      mem_read_in   = 1'b1;
      mem_write_in  = 1'b0;
      mem_to_reg_in = 1'b1;
      reg_write_in  = 1'b1;
      alu_result_in = 16'h0080;
      rd_in         = 4'd2;
      dmem_ack      = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("pre_rst_req", dmem_req, 1'b1);
      #2;
      drive_idle();
      rst = 1'b1;
      #1;
      check("arst_req",   dmem_req, 1'b0);
      check("arst_addr",  dmem_addr, 16'h0);
      check("arst_stall", mem_stall, 1'b0);
      check("arst_regwr", reg_write, 1'b0);
      check("arst_res",   alu_result, 16'h0);
      check("arst_mdata", mem_data, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hCAFE;
      @(negedge clk);
      check("late_ack_stall", mem_stall, 1'b0);
      check("late_ack_req",   dmem_req, 1'b0);
      next_cycle();
      dmem_ack = 1'b0;
      @(negedge clk);
      check("late_ack_stall2", mem_stall, 1'b0);
      check("late_ack_mdata",  mem_data, 16'h0);
      next_cycle();

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            logic v;
            v = 1'($urandom);
            alu_op(v, v ? 1'b0 : 1'($urandom), v ? 1'b0 : 1'($urandom),
                   1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom),
                   1'($urandom));
         end else begin
            mem_txn(kind == 2, (kind == 2) & 1'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), $urandom_range(1, 6),
                    1'($urandom), 1'($urandom), 4'($urandom));
         end
      end

`ifdef MEM_TIMEOUT_EN
      // Load that is never acknowledged times out after TMO WAIT cycles
      valid_in      = 1'b1;
      mem_read_in   = 1'b1;
      mem_write_in  = 1'b0;
      mem_to_reg_in = 1'b1;
      reg_write_in  = 1'b1;
      alu_result_in = 16'h0100;
      rd_in         = 4'd6;
      dmem_ack      = 1'b0;
      next_cycle();
      for (int j = 1; j <= TMO; j++) begin
         @(negedge clk);
         check("tmo_req",   dmem_req, 1'b1);
         check("tmo_stall", mem_stall, 1'b1);
         check("tmo_fault", mem_fault, 1'b0);
         next_cycle();
      end
      @(negedge clk);
      check("tmo_done_req",   dmem_req, 1'b0);
      check("tmo_done_stall", mem_stall, 1'b0);
      check("tmo_done_fault", mem_fault, 1'b1);
      check("tmo_done_mdata", mem_data, 16'hDEAD);
      check("tmo_done_regwr", reg_write, 1'b0);
      next_cycle();
      drive_idle();
      @(negedge clk);
      check("tmo_after_fault", mem_fault, 1'b0);
      check("tmo_after_stall", mem_stall, 1'b0);
      next_cycle();
      mem_txn(1'b0, 1'b0, 16'h0200, 16'h0, 16'h1357, TMO, 1'b1, 1'b1, 4'd4);
`endif

      drive_idle();
      next_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
